// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared constants and types for the data-memory arbiter.
//   DA_WIDTH / DA_ADDR_WIDTH : default word and word-address widths
//   da_state_e               : arbiter FSM states
//   DA_PORT_CPU / DA_PORT_DMA: requester port ids
package dram_arbiter_pkg;

   localparam int unsigned DA_WIDTH      = 32;
   localparam int unsigned DA_ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      DA_IDLE    = 2'd0,
      DA_RD_WAIT = 2'd1,
      DA_RMW     = 2'd2
   } da_state_e;

   localparam logic DA_PORT_CPU = 1'b0;
   localparam logic DA_PORT_DMA = 1'b1;

endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: two-port requester bus of the data-memory arbiter.
// Port p uses bit p of the per-port vectors and slice p of the packed fields.
//   req_i/we_i/addr_i/wdata_i/be_i : requests (held until gnt_o)
//   gnt_o                          : one-cycle accept pulse per port
//   rvalid_o/rdata_o               : read return, one-cycle pulse per port
// Modports: slave = arbiter side, master = requester side.
interface dram_arbiter_if
   import dram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DA_ADDR_WIDTH,
   parameter int unsigned WIDTH      = DA_WIDTH
);
   localparam int unsigned BE_W = WIDTH / 8;

   logic [1:0]              req_i;
   logic [1:0]              we_i;
   logic [2*ADDR_WIDTH-1:0] addr_i;
   logic [2*WIDTH-1:0]      wdata_i;
   logic [2*BE_W-1:0]       be_i;
   logic [1:0]              gnt_o;
   logic [1:0]              rvalid_o;
   logic [WIDTH-1:0]        rdata_o;

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output gnt_o, rvalid_o, rdata_o
   );

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  gnt_o, rvalid_o, rdata_o
   );

endinterface

// File: rtl/dram_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter.
//   req[1:0] : requests
//   last_gnt : id of the port granted most recently
//   en       : arbitration enable; gnt is zero when low
//   gnt[1:0] : one-hot grant (zero when no request or not enabled)
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   input  logic       en,
   output logic [1:0] gnt
);

   // On contention the port that did not win last time is served.
   always_comb begin
      gnt    = '0;
      gnt[0] = en & req[0] & (~req[1] | last_gnt);
      gnt[1] = en & req[1] & (~req[0] | ~last_gnt);
   end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter between the CPU load/store unit (port 0)
// and the DMA/debug loader (port 1) in front of a single-port block RAM with a
// 1-cycle registered read and no byte enables. Reads return one cycle after
// the grant; partial stores are done as read-modify-write.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : requester bus (dram_arbiter_if.slave)
//   mem_we_o    : RAM write enable
//   mem_addr_o  : RAM word address
//   mem_din_o   : RAM write data
//   mem_dout_i  : RAM read data, valid one cycle after the address
module dram_arbiter
   import dram_arbiter_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH = DA_ADDR_WIDTH,
   parameter  int unsigned WIDTH      = DA_WIDTH,
   localparam int unsigned BE_W       = WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dram_arbiter_if.slave         bus,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0]      mem_din_o,
   input  logic [WIDTH-1:0]      mem_dout_i
);

   da_state_e             state_q, state_d;
   logic                  last_gnt_q;
   logic                  cap_id_q;
   logic [ADDR_WIDTH-1:0] cap_addr_q;
   logic [WIDTH-1:0]      cap_wdata_q;
   logic [BE_W-1:0]       cap_be_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0]      mem_din_q;

   logic                  arb_en;
   logic [1:0]            gnt;
   logic [1:0]            rvalid;
   logic                  win_id;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [WIDTH-1:0]      win_wdata;
   logic [BE_W-1:0]       win_be;

   // Grants are combinational, so they are also held off while reset is
   // asserted to keep every output quiet during reset.
   assign arb_en = (state_q == DA_IDLE) && rst_n;

   rr_arb2 u_rr_arb2 (
      .req      (bus.req_i),
      .last_gnt (last_gnt_q),
      .en       (arb_en),
      .gnt      (gnt)
   );

   assign win_id    = gnt[1];
   assign win_we    = win_id ? bus.we_i[1] : bus.we_i[0];
   assign win_addr  = win_id ? bus.addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.addr_i[ADDR_WIDTH-1:0];
   assign win_wdata = win_id ? bus.wdata_i[2*WIDTH-1:WIDTH] : bus.wdata_i[WIDTH-1:0];
   assign win_be    = win_id ? bus.be_i[2*BE_W-1:BE_W] : bus.be_i[BE_W-1:0];

   always_comb begin
      state_d    = state_q;
      rvalid     = '0;
      bus.rdata_o = '0;
      mem_we_o   = 1'b0;
      // RAM address/data hold their last driven values when not in use.
      mem_addr_o = mem_addr_q;
      mem_din_o  = mem_din_q;
      unique case (state_q)
         DA_IDLE: begin
            if (|gnt) begin
               mem_addr_o = win_addr;
               if (!win_we) begin
                  state_d = DA_RD_WAIT;
               end else if (&win_be) begin
                  mem_we_o  = 1'b1;
                  mem_din_o = win_wdata;
               end else if (|win_be) begin
                  state_d = DA_RMW;
               end
            end
         end
         DA_RD_WAIT: begin
            rvalid      = cap_id_q ? 2'b10 : 2'b01;
            bus.rdata_o = mem_dout_i;
            state_d     = DA_IDLE;
         end
         DA_RMW: begin
            mem_we_o   = 1'b1;
            mem_addr_o = cap_addr_q;
            for (int unsigned i = 0; i < BE_W; i++) begin
               mem_din_o[8*i +: 8] = cap_be_q[i] ? cap_wdata_q[8*i +: 8] : mem_dout_i[8*i +: 8];
            end
            state_d = DA_IDLE;
         end
         default: state_d = DA_IDLE;
      endcase
   end

   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = rvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DA_IDLE;
         last_gnt_q  <= DA_PORT_DMA;
         cap_id_q    <= DA_PORT_CPU;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
         cap_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_o;
         mem_din_q  <= mem_din_o;
         if (|gnt) begin
            last_gnt_q  <= win_id;
            cap_id_q    <= win_id;
            cap_addr_q  <= win_addr;
            cap_wdata_q <= win_wdata;
            cap_be_q    <= win_be;
         end
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed, table-driven bench for dram_arbiter with a
// behavioural single-port RAM (1-cycle registered read).
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = '0;

   logic [31:0] ram [0:4095];
   logic        ram_ready = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   dram_arbiter_if #(.ADDR_WIDTH(12), .WIDTH(32)) bus ();

   dram_arbiter #(.ADDR_WIDTH(12), .WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_din_o  (mem_din),
      .mem_dout_i (mem_dout)
   );

   always #5 clk = ~clk;

   // RAM model; contents are loaded on the first clock (inside reset).
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 4096; i++) ram[i] <= '0;
         ram[12'h010] <= 32'h01010101;
         ram[12'h020] <= 32'hDEADBEEF;
         ram[12'h030] <= 32'hAABBCCDD;
         ram[12'h040] <= 32'h40404040;
         ram[12'h041] <= 32'h41414141;
         ram[12'h050] <= 32'h50505050;
         ram_ready    <= 1'b1;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_din;
         mem_dout <= ram[mem_addr];
      end
   end

   typedef struct {
      logic [1:0]  req, we;
      logic [11:0] a0, a1;
      logic [31:0] d0, d1;
      logic [3:0]  b0, b1;
      logic [1:0]  gnt, rv;
      logic [31:0] rdata;
      logic        mwe;
      logic        ca;
      logic [11:0] maddr;
      logic        cd;
      logic [31:0] mdin;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [1:0] req, we, input logic [11:0] a0, a1,
                      input logic [31:0] d0, d1, input logic [3:0] b0, b1,
                      input logic [1:0] gnt, rv, input logic [31:0] rdata,
                      input logic mwe, ca, input logic [11:0] maddr,
                      input logic cd, input logic [31:0] mdin);
      vec_t v;
      v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.b0 = b0; v.b1 = b1; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.mwe = mwe; v.ca = ca; v.maddr = maddr; v.cd = cd; v.mdin = mdin;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
   endtask

   task automatic drive(input logic [1:0] req, we, input logic [11:0] a0, a1,
                        input logic [31:0] d0, d1, input logic [3:0] b0, b1);
      bus.req_i   = req;
      bus.we_i    = we;
      bus.addr_i  = {a1, a0};
      bus.wdata_i = {d1, d0};
      bus.be_i    = {b1, b0};
   endtask

   task automatic chk_quiet(input string tag, input int idx);
      chk({tag, ".gnt"},    idx, 32'(bus.gnt_o),    32'h0);
      chk({tag, ".rvalid"}, idx, 32'(bus.rvalid_o), 32'h0);
      chk({tag, ".rdata"},  idx, bus.rdata_o,       32'h0);
      chk({tag, ".mem_we"}, idx, 32'(mem_we),       32'h0);
      chk({tag, ".maddr"},  idx, 32'(mem_addr),     32'h0);
      chk({tag, ".mdin"},   idx, mem_din,           32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(2'b00, 2'b00, 12'h0, 12'h0, 32'h0, 32'h0, 4'h0, 4'h0);

      // Contention (both reading 0x040 / 0x041), first grant to port 0
      add(2'b11, 2'b00, 12'h040, 12'h041, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b00, 32'h0,         1'b0, 1'b1, 12'h040, 1'b0, 32'h0);
      add(2'b11, 2'b00, 12'h040, 12'h041, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b01, 32'h40404040, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      add(2'b11, 2'b00, 12'h040, 12'h041, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b00, 32'h0,         1'b0, 1'b1, 12'h041, 1'b0, 32'h0);
      add(2'b11, 2'b00, 12'h040, 12'h041, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b10, 32'h41414141, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      add(2'b11, 2'b00, 12'h040, 12'h041, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b00, 32'h0,         1'b0, 1'b1, 12'h040, 1'b0, 32'h0);
      add(2'b11, 2'b00, 12'h040, 12'h041, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b01, 32'h40404040, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      // Single read, port 1, 0x020
      add(2'b10, 2'b00, 12'h000, 12'h020, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b00, 32'h0,         1'b0, 1'b1, 12'h020, 1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b10, 32'hDEADBEEF, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      // Back-to-back full writes, then readback
      add(2'b01, 2'b01, 12'h005, 12'h000, 32'h11111111, 32'h0, 4'hF, 4'h0, 2'b01, 2'b00, 32'h0, 1'b1, 1'b1, 12'h005, 1'b1, 32'h11111111);
      add(2'b01, 2'b01, 12'h006, 12'h000, 32'h22222222, 32'h0, 4'hF, 4'h0, 2'b01, 2'b00, 32'h0, 1'b1, 1'b1, 12'h006, 1'b1, 32'h22222222);
      add(2'b01, 2'b00, 12'h005, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b00, 32'h0,         1'b0, 1'b1, 12'h005, 1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b01, 32'h11111111, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      add(2'b10, 2'b00, 12'h000, 12'h006, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b00, 32'h0,         1'b0, 1'b1, 12'h006, 1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b10, 32'h22222222, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      // Partial write be=0011 to 0x030, then readback
      add(2'b01, 2'b01, 12'h030, 12'h000, 32'h12345678, 32'h0, 4'h3, 4'h0, 2'b01, 2'b00, 32'h0, 1'b0, 1'b1, 12'h030, 1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b00, 32'h0,         1'b1, 1'b1, 12'h030, 1'b1, 32'hAABB5678);
      add(2'b01, 2'b00, 12'h030, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b00, 32'h0,         1'b0, 1'b1, 12'h030, 1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b01, 32'hAABB5678, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      // Empty write port 1 to 0x050 (din holds last value), then readback
      add(2'b10, 2'b10, 12'h000, 12'h050, 32'h0, 32'hFFFFFFFF, 4'h0, 4'h0, 2'b10, 2'b00, 32'h0, 1'b0, 1'b1, 12'h050, 1'b1, 32'hAABB5678);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      add(2'b10, 2'b00, 12'h000, 12'h050, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b00, 32'h0,         1'b0, 1'b1, 12'h050, 1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b10, 32'h50505050, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      // Request arriving in RD_WAIT waits for the next IDLE cycle
      add(2'b01, 2'b00, 12'h010, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 2'b00, 32'h0,         1'b0, 1'b1, 12'h010, 1'b0, 32'h0);
      add(2'b10, 2'b00, 12'h000, 12'h020, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b01, 32'h01010101, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);
      add(2'b10, 2'b00, 12'h000, 12'h020, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 2'b00, 32'h0,         1'b0, 1'b1, 12'h020, 1'b0, 32'h0);
      add(2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b10, 32'hDEADBEEF, 1'b0, 1'b0, 12'h0,   1'b0, 32'h0);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("rst", 0);
      rst_n = 1'b1;

      // Port 0 read of 0x010, then reset asserted mid-RD_WAIT
      @(posedge clk); #1;
      drive(2'b01, 2'b00, 12'h010, 12'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("pre.gnt",   0, 32'(bus.gnt_o), 32'h1);
      chk("pre.maddr", 0, 32'(mem_addr),  32'h010);
      @(posedge clk); #1;
      drive(2'b00, 2'b00, 12'h0, 12'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      chk("pre.rvalid", 0, 32'(bus.rvalid_o), 32'h1);
      chk("pre.rdata",  0, bus.rdata_o,       32'h01010101);
      #2 rst_n = 1'b0;
      #1 chk_quiet("midrst", 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post.rvalid", 0, 32'(bus.rvalid_o), 32'h0);
      chk("post.mem_we", 0, 32'(mem_we),       32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk); #1;
         drive(vq[i].req, vq[i].we, vq[i].a0, vq[i].a1, vq[i].d0, vq[i].d1, vq[i].b0, vq[i].b1);
         @(negedge clk);
         chk("vec.gnt",    i, 32'(bus.gnt_o),    32'(vq[i].gnt));
         chk("vec.rvalid", i, 32'(bus.rvalid_o), 32'(vq[i].rv));
         chk("vec.mem_we", i, 32'(mem_we),       32'(vq[i].mwe));
         if (vq[i].rv != 2'b00) chk("vec.rdata", i, bus.rdata_o, vq[i].rdata);
         if (vq[i].ca) chk("vec.maddr", i, 32'(mem_addr), 32'(vq[i].maddr));
         if (vq[i].cd) chk("vec.mdin",  i, mem_din,       vq[i].mdin);
      end

      @(posedge clk); #1;
      drive(2'b00, 2'b00, 12'h0, 12'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      @(negedge clk);
      chk("ram.050", 0, ram[12'h050], 32'h50505050);
      chk("ram.030", 0, ram[12'h030], 32'hAABB5678);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
